// File: rtl/fetch_queue.sv
// Instruction fetch queue between instruction memory and decode.
// Holds {PC, instruction} pairs first-word-fall-through and drops them all on a front-end flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Flush,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [AW-1:0]            PCIn,
  input  logic [DW-1:0]            InstrIn,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [AW-1:0]            PCOut,
  output logic [AW-1:0]            PCPlus4Out,
  output logic [DW-1:0]            InstrOut,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW+DW-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             full, empty, push, pop;
  logic [AW+DW-1:0] head;
  logic [AW-1:0]    head_pc;

  always_comb begin
    full  = (count_reg == CW'(DEPTH));
    empty = (count_reg == '0);
    // Flush suppresses any handshake presented on the same edge.
    push  = InValid & ~full & ~Flush;
    pop   = OutReady & ~empty & ~Flush;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (Flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
      if (push && !pop)      count_next = count_reg + CW'(1);
      else if (pop && !push) count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: every read of it is masked while the queue is empty.
  always_ff @(posedge Clk) begin
    if (push) mem_reg[wr_ptr_reg] <= {PCIn, InstrIn};
  end

  always_comb begin
    head       = mem_reg[rd_ptr_reg];
    head_pc    = head[AW+DW-1:DW];
    PCOut      = empty ? '0 : head_pc;
    PCPlus4Out = empty ? '0 : head_pc + AW'(4);
    InstrOut   = empty ? '0 : head[DW-1:0];
    InReady    = ~full;
    OutValid   = ~empty;
    Count      = count_reg;
    Full       = full;
    Empty      = empty;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, 32-bit PC and instruction).
module tb_fetch_queue;

  logic        Clk;
  logic        Reset;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [31:0] PCIn;
  logic [31:0] InstrIn;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] PCOut;
  logic [31:0] PCPlus4Out;
  logic [31:0] InstrOut;
  logic [2:0]  Count;
  logic        Full;
  logic        Empty;

  int tests_run;
  int tests_failed;

  fetch_queue #(.DEPTH(4), .DW(32), .AW(32)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady), .PCIn(PCIn), .InstrIn(InstrIn),
    .OutValid(OutValid), .OutReady(OutReady),
    .PCOut(PCOut), .PCPlus4Out(PCPlus4Out), .InstrOut(InstrOut),
    .Count(Count), .Full(Full), .Empty(Empty)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
      $display("[TB] ok   %-22s observed=%0h", tag, observed);
    else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    PCIn = '0; InstrIn = '0;

    // 1: reset, then release away from the edge
    #12;
    check("rst_count_during", 64'(Count), 64'd0);
    Reset = 1'b0;
    #1;
    check("rst_count", 64'(Count), 64'd0);
    check("rst_empty", 64'(Empty), 64'd1);
    check("rst_full", 64'(Full), 64'd0);
    check("rst_inready", 64'(InReady), 64'd1);
    check("rst_outvalid", 64'(OutValid), 64'd0);
    check("rst_pcout", 64'(PCOut), 64'd0);
    check("rst_pcplus4", 64'(PCPlus4Out), 64'd0);

    // 2: fill with PC 0,4,8,12
    @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      InValid = 1'b1;
      PCIn    = 32'(4 * i);
      InstrIn = 32'h2008_0001 + 32'(i);
      step();
      if (i == 0) begin
        check("fill_first_valid", 64'(OutValid), 64'd1);
        check("fill_first_count", 64'(Count), 64'd1);
      end
    end
    InValid = 1'b0;
    check("fill_full", 64'(Full), 64'd1);
    check("fill_inready", 64'(InReady), 64'd0);
    check("fill_count", 64'(Count), 64'd4);
    check("fill_pcout", 64'(PCOut), 64'd0);
    check("fill_pcplus4", 64'(PCPlus4Out), 64'd4);
    check("fill_instr", 64'(InstrOut), 64'h2008_0001);

    // 3: from full, pop only on first edge, then push+pop
    OutReady = 1'b1; InValid = 1'b1; PCIn = 32'd16; InstrIn = 32'h2008_0005;
    step();
    check("full_pop_count", 64'(Count), 64'd3);
    check("full_pop_pcout", 64'(PCOut), 64'd4);
    check("full_pop_pc4", 64'(PCPlus4Out), 64'd8);
    step();
    check("pushpop_count", 64'(Count), 64'd3);
    check("pushpop_pcout", 64'(PCOut), 64'd8);
    InValid = 1'b0;
    step();
    check("drain_pc12", 64'(PCOut), 64'd12);
    step();
    check("drain_pc16", 64'(PCOut), 64'd16);
    check("drain_instr16", 64'(InstrOut), 64'h2008_0005);
    step();
    check("drain_empty", 64'(Empty), 64'd1);
    check("drain_instr_zero", 64'(InstrOut), 64'd0);

    // 4: stream 10 pairs across the pointer wrap
    InValid = 1'b1; OutReady = 1'b1;
    for (int k = 0; k < 10; k++) begin
      PCIn    = 32'(4 * k);
      InstrIn = 32'h0000_1000 + 32'(k);
      step();
      check($sformatf("stream_pc_%0d", k), 64'(PCOut), 64'(4 * k));
      check($sformatf("stream_cnt_%0d", k), 64'(Count), 64'd1);
    end
    InValid = 1'b0;
    step();
    check("stream_end_empty", 64'(Empty), 64'd1);

    // 5: three entries, then flush with push and pop requested
    OutReady = 1'b0; InValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PCIn = 32'h100 + 32'(4 * i); InstrIn = 32'hA000_0000 + 32'(i);
      step();
    end
    check("preflush_count", 64'(Count), 64'd3);
    Flush = 1'b1; InValid = 1'b1; OutReady = 1'b1; PCIn = 32'h10C; InstrIn = 32'hA000_0003;
    step();
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    check("flush_count", 64'(Count), 64'd0);
    check("flush_empty", 64'(Empty), 64'd1);
    check("flush_outvalid", 64'(OutValid), 64'd0);
    check("flush_pcout", 64'(PCOut), 64'd0);
    step();
    check("flush_hold_valid", 64'(OutValid), 64'd0);
    InValid = 1'b1; PCIn = 32'h200; InstrIn = 32'hB000_0000;
    step();
    InValid = 1'b0;
    check("postflush_pc", 64'(PCOut), 64'h200);
    check("postflush_count", 64'(Count), 64'd1);
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    check("postflush_empty", 64'(Empty), 64'd1);

    // 6: asynchronous reset between edges with two entries queued
    InValid = 1'b1;
    PCIn = 32'h300; InstrIn = 32'hC000_0000;
    step();
    PCIn = 32'h304; InstrIn = 32'hC000_0001;
    step();
    InValid = 1'b0;
    check("prereset_count", 64'(Count), 64'd2);
    #3;
    Reset = 1'b1;
    #1;
    check("async_rst_count", 64'(Count), 64'd0);
    check("async_rst_valid", 64'(OutValid), 64'd0);
    check("async_rst_pcout", 64'(PCOut), 64'd0);
    #2;
    Reset = 1'b0;
    InValid = 1'b1; PCIn = 32'h40; InstrIn = 32'hD000_0000;
    step();
    InValid = 1'b0;
    check("after_rst_valid", 64'(OutValid), 64'd1);
    check("after_rst_pcout", 64'(PCOut), 64'h40);
    check("after_rst_pc4", 64'(PCPlus4Out), 64'h44);
    check("after_rst_count", 64'(Count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
